// File: rtl/dendrite_compartment_pkg.sv
// Shared fixed-point types and helpers for the dendrite compartment.
package dendrite_compartment_pkg;

  localparam int ACC_WIDTH = 24;

  typedef logic signed [ACC_WIDTH-1:0] fpAccType;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767) return 16'sh7fff;
    if (v < -34'sd32768) return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/dendrite_leak_unit.sv
// Conductance leak toward E_l: sat16((g_leak * (E_l - vmem)) >>> LEAK_SHIFT).
module dendrite_leak_unit
  import dendrite_compartment_pkg::*;
#(
  parameter int LEAK_SHIFT = 15
) (
  input  logic signed [15:0] vmem_i,
  input  logic signed [15:0] e_l_i,
  input  logic        [15:0] g_leak_i,
  output logic signed [15:0] leak_o
);

  logic signed [16:0] diff;
  logic signed [32:0] prod;
  logic signed [32:0] shd;

  // g_leak is unsigned Q1.15; a zero MSB keeps it positive in the signed multiply
  assign diff   = 17'(e_l_i) - 17'(vmem_i);
  assign prod   = diff * $signed({1'b0, g_leak_i});
  assign shd    = prod >>> LEAK_SHIFT;
  assign leak_o = sat16(34'(shd));

endmodule

// File: rtl/dendrite_compartment.sv
// Point-compartment membrane integrator: serial current sum, leak, fire, refractory.
module dendrite_compartment
  import dendrite_compartment_pkg::*;
#(
  parameter int NUM_SYN       = 8,
  parameter int CURRENT_SHIFT = 4,
  parameter int LEAK_SHIFT    = 15,
  parameter int REFRAC_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [NUM_SYN*16-1:0]  syn_current,
  output logic [15:0]            vmem_out,
  output logic                   spike_out,
  output logic                   busy,
  output logic                   tick_overrun,
  input  logic                   cfg_data_clk,
  input  logic [15:0]            cfg_data_in,
  output logic [15:0]            cfg_data_out
);

  localparam int IW = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
  localparam int VW = 26;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_LEAK, S_UPDATE, S_REFR
  } state_e;

  state_e state_q, state_d;

  logic signed [15:0] e_l_q, v_th_q, v_rst_q;
  logic [15:0] g_leak_q, refrac_cfg_q, cfg_out_q;

  logic [IW-1:0]           idx_q;
  fpAccType                acc_q;
  logic signed [15:0]      leak_q, vmem_q;
  logic                    spike_q, ovr_q;
  logic [REFRAC_WIDTH-1:0] refrac_q;

  logic signed [15:0] syn_sel, leak_w, v_next;
  fpAccType           acc_sh;
  logic signed [VW-1:0] v_sum;
  logic               fire;
  logic               unused_cfg;

  // Config shift chain, loaded while the compartment is idle
  always_ff @(posedge cfg_data_clk) begin
    e_l_q        <= cfg_data_in;
    g_leak_q     <= e_l_q;
    v_th_q       <= g_leak_q;
    v_rst_q      <= v_th_q;
    refrac_cfg_q <= v_rst_q;
    cfg_out_q    <= refrac_cfg_q;
  end

  assign cfg_data_out = cfg_out_q;
  assign unused_cfg   = ^refrac_cfg_q;

  dendrite_leak_unit #(
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_leak (
    .vmem_i   (vmem_q),
    .e_l_i    (e_l_q),
    .g_leak_i (g_leak_q),
    .leak_o   (leak_w)
  );

  assign syn_sel = syn_current[{idx_q, 4'b0000} +: 16];
  assign acc_sh  = acc_q >>> CURRENT_SHIFT;
  assign v_sum   = VW'(vmem_q) + VW'(acc_sh) + VW'(leak_q);
  assign v_next  = sat16(34'(v_sum));
  assign fire    = (v_next >= v_th_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (tick) state_d = (refrac_q != '0) ? S_REFR : S_ACCUM;
      S_ACCUM:  if (idx_q == IW'(NUM_SYN - 1)) state_d = S_LEAK;
      S_LEAK:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      S_REFR:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      acc_q    <= '0;
      leak_q   <= '0;
      vmem_q   <= '0;
      spike_q  <= 1'b0;
      ovr_q    <= 1'b0;
      refrac_q <= '0;
    end else begin
      spike_q <= 1'b0;
      if (tick && state_q != S_IDLE) ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            idx_q <= '0;
            acc_q <= '0;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_q + fpAccType'(syn_sel);
          idx_q <= idx_q + IW'(1);
        end
        S_LEAK: leak_q <= leak_w;
        S_UPDATE: begin
          if (fire) begin
            vmem_q   <= v_rst_q;
            spike_q  <= 1'b1;
            refrac_q <= refrac_cfg_q[REFRAC_WIDTH-1:0];
          end else begin
            vmem_q <= v_next;
          end
        end
        S_REFR: begin
          vmem_q   <= v_rst_q;
          refrac_q <= refrac_q - REFRAC_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign vmem_out     = vmem_q;
  assign spike_out    = spike_q;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_dendrite_compartment.sv
// Directed bench for dendrite_compartment with hand-computed vectors.
module tb_dendrite_compartment;

  logic         clk = 0;
  logic         reset = 1;
  logic         tick = 0;
  logic [127:0] syn = '0;
  logic [15:0]  vmem_out;
  logic         spike_out, busy, tick_overrun;
  logic         cfg_data_clk = 0;
  logic [15:0]  cfg_data_in = '0;
  logic [15:0]  cfg_data_out;

  int total = 0;
  int bad = 0;
  int nb;
  logic spk;
  int nspk;

  dendrite_compartment dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .syn_current  (syn),
    .vmem_out     (vmem_out),
    .spike_out    (spike_out),
    .busy         (busy),
    .tick_overrun (tick_overrun),
    .cfg_data_clk (cfg_data_clk),
    .cfg_data_in  (cfg_data_in),
    .cfg_data_out (cfg_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cfg_load(input logic [15:0] mark, input logic [15:0] rf,
                          input logic [15:0] vr, input logic [15:0] vt,
                          input logic [15:0] gl, input logic [15:0] el);
    logic [15:0] w [6];
    w = '{mark, rf, vr, vt, gl, el};
    for (int i = 0; i < 6; i++) begin
      cfg_data_in = w[i];
      #2 cfg_data_clk = 1;
      #2 cfg_data_clk = 0;
    end
    #1 chk("chain", {16'h0, cfg_data_out}, {16'h0, mark});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic run_tick(output int n, output logic s);
    @(posedge clk); #1 tick = 1;
    @(posedge clk); #1 tick = 0;
    n = 0;
    s = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
      if (spike_out) s = 1;
    end
  endtask

  initial begin
    // integrate config: thresh 0x0400, no leak, reset to 0, no refractory
    cfg_load(16'hA5A5, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000);
    do_reset();
    chk("rst_vmem", vmem_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spike", spike_out, 0);
    chk("rst_ovr", tick_overrun, 0);

    syn[15:0] = 16'h0100;
    run_tick(nb, spk);
    chk("int1_vmem", vmem_out, 16'h0010);
    chk("int1_busy", nb, 10);
    chk("int1_spk", spk, 0);
    nspk = 0;
    for (int i = 0; i < 62; i++) begin
      run_tick(nb, spk);
      if (spk) nspk++;
    end
    chk("int63_vmem", vmem_out, 16'h03F0);
    chk("int63_nspk", nspk, 0);
    run_tick(nb, spk);
    chk("int64_spk", spk, 1);
    chk("int64_vmem", vmem_out, 16'h0000);

    // reset during ACCUM aborts without update
    run_tick(nb, spk);
    chk("pre_rst_vmem", vmem_out, 16'h0010);
    @(posedge clk); #1 tick = 1;
    @(posedge clk); #1 tick = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("mid_rst_vmem", vmem_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_spike", spike_out, 0);
    repeat (12) @(posedge clk);
    #1 chk("mid_rst_after", vmem_out, 0);
    chk("mid_rst_busy2", busy, 0);

    // leak toward E_l = 0x0200 with g = 0.5
    cfg_load(16'h1111, 16'h0000, 16'h0000, 16'h7FFF, 16'h4000, 16'h0200);
    syn = '0;
    do_reset();
    run_tick(nb, spk);
    chk("leak1", vmem_out, 16'h0100);
    run_tick(nb, spk);
    chk("leak2", vmem_out, 16'h0180);
    run_tick(nb, spk);
    chk("leak3", vmem_out, 16'h01C0);
    cfg_load(16'h1212, 16'h0000, 16'h0000, 16'h7FFF, 16'h4000, 16'h0000);
    run_tick(nb, spk);
    chk("leak_neg", vmem_out, 16'h00E0);

    // spike and refractory
    cfg_load(16'h2222, 16'h0002, 16'hFF00, 16'h0020, 16'h0000, 16'h0000);
    do_reset();
    syn[15:0] = 16'h0200;
    run_tick(nb, spk);
    chk("ref1_spk", spk, 1);
    chk("ref1_vmem", vmem_out, 16'hFF00);
    run_tick(nb, spk);
    chk("ref2_busy", nb, 1);
    chk("ref2_spk", spk, 0);
    chk("ref2_vmem", vmem_out, 16'hFF00);
    run_tick(nb, spk);
    chk("ref3_busy", nb, 1);
    chk("ref3_vmem", vmem_out, 16'hFF00);
    run_tick(nb, spk);
    chk("ref4_busy", nb, 10);
    chk("ref4_vmem", vmem_out, 16'hFF20);
    chk("ref4_spk", spk, 0);

    // saturation both directions
    cfg_load(16'h3333, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
    do_reset();
    syn = {8{16'h7FFF}};
    run_tick(nb, spk);
    chk("satp1", vmem_out, 16'h3FFF);
    run_tick(nb, spk);
    chk("satp2", vmem_out, 16'h7FFE);
    chk("satp2_spk", spk, 0);
    run_tick(nb, spk);
    chk("satp3", vmem_out, 16'h7FFF);
    chk("satp3_spk", spk, 1);
    syn = {8{16'h8000}};
    run_tick(nb, spk);
    chk("satn1", vmem_out, 16'h3FFF);
    run_tick(nb, spk);
    chk("satn2", vmem_out, 16'hFFFF);
    run_tick(nb, spk);
    chk("satn3", vmem_out, 16'hBFFF);
    run_tick(nb, spk);
    chk("satn4", vmem_out, 16'h8000);
    run_tick(nb, spk);
    chk("satn5", vmem_out, 16'h8000);
    chk("satn5_spk", spk, 0);

    // tick overrun
    cfg_load(16'h4444, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000);
    do_reset();
    syn = '0;
    syn[15:0] = 16'h0100;
    chk("ovr_pre", tick_overrun, 0);
    @(posedge clk); #1 tick = 1;
    @(posedge clk); #1 tick = 0;
    repeat (2) @(posedge clk);
    #1 tick = 1;
    @(posedge clk); #1 tick = 0;
    repeat (15) @(posedge clk);
    #1 chk("ovr_flag", tick_overrun, 1);
    chk("ovr_vmem", vmem_out, 16'h0010);
    run_tick(nb, spk);
    chk("ovr_vmem2", vmem_out, 16'h0020);
    chk("ovr_sticky", tick_overrun, 1);
    do_reset();
    chk("ovr_clr", tick_overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
